// File: rtl/jtpang_romarb_pkg.sv
// rtl/jtpang_romarb_pkg.sv - shared types and constants for the Pang ROM arbiter
package jtpang_romarb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    WAIT_RDY = 2'd2
  } state_t;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_PCM = 1'b1
  } gnt_t;

  localparam logic [21:0] PCM_OFFSET_DEF = 22'h10_0000;

endpackage

// File: rtl/jtpang_romarb_if.sv
// rtl/jtpang_romarb_if.sv - SDRAM bank read handshake bundle
interface jtpang_romarb_if;
  logic [21:0] sdram_addr;
  logic        sdram_rd;
  logic        sdram_ack;
  logic        sdram_rdy;
  logic [15:0] data_read;

  modport master (
    output sdram_addr,
    output sdram_rd,
    input  sdram_ack,
    input  sdram_rdy,
    input  data_read
  );

  modport slave (
    input  sdram_addr,
    input  sdram_rd,
    output sdram_ack,
    output sdram_rdy,
    output data_read
  );
endinterface

// File: rtl/jtpang_romarb_cache.sv
// rtl/jtpang_romarb_cache.sv - one-word hit cache with byte select for an 8-bit reader
module jtpang_romarb_cache #(
  parameter int AW = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          fill,
  input  logic [AW-2:0] fill_tag,
  input  logic [15:0]   fill_data,
  output logic          hit,
  output logic [7:0]    dout
);

  logic          valid_q, valid_d;
  logic [AW-2:0] tag_q, tag_d;
  logic [15:0]   word_q, word_d;
  logic [7:0]    dout_q, dout_d;

  assign hit = cs & valid_q & (tag_q == addr[AW-1:1]);

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    word_d  = word_q;
    if (fill) begin
      valid_d = 1'b1;
      tag_d   = fill_tag;
      word_d  = fill_data;
    end
  end

  // Output follows the cache on a hit and otherwise keeps the last byte shown
  always_comb begin
    dout_d = dout_q;
    if (hit) dout_d = addr[0] ? word_q[15:8] : word_q[7:0];
  end

  assign dout = dout_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      word_q  <= '0;
      dout_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      word_q  <= word_d;
      dout_q  <= dout_d;
    end
  end

endmodule

// File: rtl/jtpang_romarb.sv
// rtl/jtpang_romarb.sv - round-robin SDRAM bank sharing between Pang CPU and PCM ROM readers
// Optional miss-cycle statistics when JTPANG_ROMARB_STATS_EN is defined.
module jtpang_romarb
  import jtpang_romarb_pkg::*;
#(
  parameter int          CPU_AW     = 17,
  parameter int          PCM_AW     = 18,
  parameter logic [21:0] PCM_OFFSET = PCM_OFFSET_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_cs,
  input  logic [CPU_AW-1:0] cpu_addr,
  output logic [7:0]        cpu_data,
  output logic              cpu_ok,
  input  logic              pcm_cs,
  input  logic [PCM_AW-1:0] pcm_addr,
  output logic [7:0]        pcm_data,
  output logic              pcm_ok,
  jtpang_romarb_if.master   bus
`ifdef JTPANG_ROMARB_STATS_EN
  ,
  input  logic [1:0]        st_sel,
  output logic [7:0]        st_dout
`endif
);

  state_t             state_q, state_d;
  gnt_t               gnt_q, gnt_d;
  gnt_t               last_q, last_d;
  gnt_t               pick;
  logic               rd_q, rd_d;
  logic [21:0]        addr_q, addr_d;
  logic [CPU_AW-2:0]  cpu_tag_q, cpu_tag_d;
  logic [PCM_AW-2:0]  pcm_tag_q, pcm_tag_d;
  logic               fill;
  logic               cpu_hit, pcm_hit;
  logic               cpu_miss, pcm_miss;
  logic [21:0]        cpu_word, pcm_word;

  assign cpu_word = 22'(cpu_addr[CPU_AW-1:1]);
  assign pcm_word = PCM_OFFSET + 22'(pcm_addr[PCM_AW-1:1]);
  assign cpu_miss = cpu_cs & ~cpu_hit;
  assign pcm_miss = pcm_cs & ~pcm_hit;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    rd_d      = rd_q;
    addr_d    = addr_q;
    cpu_tag_d = cpu_tag_q;
    pcm_tag_d = pcm_tag_q;
    fill      = 1'b0;
    pick      = GNT_CPU;
    case (state_q)
      IDLE: begin
        if (cpu_miss | pcm_miss) begin
          // The round-robin flag only moves when both sides were actually contending
          if (cpu_miss & pcm_miss) begin
            pick   = (last_q == GNT_PCM) ? GNT_CPU : GNT_PCM;
            last_d = pick;
          end else begin
            pick = cpu_miss ? GNT_CPU : GNT_PCM;
          end
          gnt_d   = pick;
          rd_d    = 1'b1;
          state_d = WAIT_ACK;
          if (pick == GNT_CPU) begin
            addr_d    = cpu_word;
            cpu_tag_d = cpu_addr[CPU_AW-1:1];
          end else begin
            addr_d    = pcm_word;
            pcm_tag_d = pcm_addr[PCM_AW-1:1];
          end
        end
      end
      WAIT_ACK: begin
        if (bus.sdram_ack) begin
          rd_d = 1'b0;
          if (bus.sdram_rdy) begin
            fill    = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT_RDY;
          end
        end
      end
      WAIT_RDY: begin
        if (bus.sdram_rdy) begin
          fill    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= GNT_CPU;
      last_q    <= GNT_PCM;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      cpu_tag_q <= '0;
      pcm_tag_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      rd_q      <= rd_d;
      addr_q    <= addr_d;
      cpu_tag_q <= cpu_tag_d;
      pcm_tag_q <= pcm_tag_d;
    end
  end

  assign bus.sdram_rd   = rd_q;
  assign bus.sdram_addr = addr_q;

  jtpang_romarb_cache #(.AW(CPU_AW)) u_cpu_cache (
    .clk       (clk),
    .rst       (rst),
    .cs        (cpu_cs),
    .addr      (cpu_addr),
    .fill      (fill & (gnt_q == GNT_CPU)),
    .fill_tag  (cpu_tag_q),
    .fill_data (bus.data_read),
    .hit       (cpu_hit),
    .dout      (cpu_data)
  );

  jtpang_romarb_cache #(.AW(PCM_AW)) u_pcm_cache (
    .clk       (clk),
    .rst       (rst),
    .cs        (pcm_cs),
    .addr      (pcm_addr),
    .fill      (fill & (gnt_q == GNT_PCM)),
    .fill_tag  (pcm_tag_q),
    .fill_data (bus.data_read),
    .hit       (pcm_hit),
    .dout      (pcm_data)
  );

  assign cpu_ok = cpu_hit;
  assign pcm_ok = pcm_hit;

`ifdef JTPANG_ROMARB_STATS_EN
  logic [15:0] cpu_mc_q, cpu_mc_d;
  logic [15:0] pcm_mc_q, pcm_mc_d;
  logic [7:0]  st_dout_q, st_dout_d;

  always_comb begin
    cpu_mc_d = cpu_mc_q;
    pcm_mc_d = pcm_mc_q;
    if (cpu_cs & ~cpu_ok & ~&cpu_mc_q) cpu_mc_d = cpu_mc_q + 16'd1;
    if (pcm_cs & ~pcm_ok & ~&pcm_mc_q) pcm_mc_d = pcm_mc_q + 16'd1;
    case (st_sel)
      2'd0:    st_dout_d = cpu_mc_q[15:8];
      2'd1:    st_dout_d = cpu_mc_q[7:0];
      2'd2:    st_dout_d = pcm_mc_q[15:8];
      default: st_dout_d = pcm_mc_q[7:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_mc_q  <= '0;
      pcm_mc_q  <= '0;
      st_dout_q <= '0;
    end else begin
      cpu_mc_q  <= cpu_mc_d;
      pcm_mc_q  <= pcm_mc_d;
      st_dout_q <= st_dout_d;
    end
  end

  assign st_dout = st_dout_q;
`endif

endmodule

// File: doc/jtpang_romarb.md
Name: jtpang_romarb

Overview:
- Shares one SDRAM bank between two 8-bit ROM readers of the Pang sound/CPU section: the banked CPU ROM and the PCM (ADPCM) sample ROM.
- Each requester has a one-word (16-bit) hit cache. Misses are sequenced through the bank's rd/ack/rdy handshake using round-robin arbitration.
- Sits between the requesters and the ba_addr/ba_rd/ba_ack/ba_rdy/data_read lines of the game top level.

Parameters:
- CPU_AW, 17: CPU ROM byte-address width.
- PCM_AW, 18: PCM ROM byte-address width.
- PCM_OFFSET, 22'h10_0000: word offset of the PCM region inside the bank. The CPU region starts at word 0.

Ports:
- clk, in, 1: system clock. Single clock domain.
- rst, in, 1: synchronous, active-high reset.
- cpu_cs, in, 1: CPU ROM read request.
- cpu_addr, in, CPU_AW: CPU byte address.
- cpu_data, out, 8: CPU read byte.
- cpu_ok, out, 1: cpu_data is valid for the current cpu_addr.
- pcm_cs, in, 1: PCM ROM read request.
- pcm_addr, in, PCM_AW: PCM byte address.
- pcm_data, out, 8: PCM read byte.
- pcm_ok, out, 1: pcm_data is valid for the current pcm_addr.
- sdram_addr, out, 22: word address to the bank.
- sdram_rd, out, 1: bank read request.
- sdram_ack, in, 1: request accepted, pulse.
- sdram_rdy, in, 1: data_read valid, pulse.
- data_read, in, 16: bank read data.

Behaviour:
- Per requester cache: valid bit, tag = addr[AW-1:1], 16-bit word.
- Hit = cs & valid & tag == addr[AW-1:1]. ok = hit, combinational, same cycle.
- Byte select: data = addr[0] ? word[15:8] : word[7:0]. data holds its last value when there is no hit.
- Miss = cs & ~hit.
- State machine:
  - IDLE: if any miss, pick the grant, drive sdram_addr, set sdram_rd=1, go to WAIT_ACK.
  - WAIT_ACK: sdram_rd held at 1 until sdram_ack, then sdram_rd=0 and go to WAIT_RDY.
  - WAIT_RDY: on sdram_rd y, write data_read into the granted cache, set valid, update tag, return to IDLE.
  - Minimum turnaround is one IDLE cycle between transfers.
- Grant when both requesters miss in IDLE: the one not granted last wins. The last-grant flag resets to PCM, so the CPU wins the first contention.
- A single miss is granted immediately.
- Address map:
  - CPU: sdram_addr = cpu_addr[CPU_AW-1:1], zero-extended.
  - PCM: sdram_addr = PCM_OFFSET + pcm_addr[PCM_AW-1:1], 22-bit add with wrap.
- Grant address is latched at IDLE->WAIT_ACK and stays stable until return to IDLE.
- Requester changes its address mid-transfer: the transfer completes and fills the cache with the latched tag. The new address then misses and is requested next.
- cs drops mid-transfer: the transfer still completes and the cache is filled.
- sdram_ack and sdram_rdy in the same cycle, while in WAIT_ACK: treat as ack followed by rdy. The cache is filled and the state goes to IDLE.
- sdram_rdy in IDLE or in WAIT_ACK without ack: ignored.
- Reset values: state IDLE, sdram_rd=0, sdram_addr=0, both valid=0, cpu_ok=pcm_ok=0, data outputs 0, last-grant=PCM.
- Reset mid-transfer: the state is abandoned and sdram_rd drops on the next edge. A late rdy is ignored. The bank controller must tolerate a dropped rd.

Optional Feature:
- Macro: JTPANG_ROMARB_STATS_EN.
- When defined, adds the following ports:
  - st_sel, in, 2.
  - st_dout, out, 8.
- Adds the following counters, each 16-bit and saturating, cleared by rst:
  - cpu_miss_cycles: cycles with cpu_cs & ~cpu_ok.
  - pcm_miss_cycles: cycles with pcm_cs & ~pcm_ok.
- st_dout selection (registered, 1-cycle latency):
  - st_sel=0: cpu_miss_cycles[15:8].
  - st_sel=1: cpu_miss_cycles[7:0].
  - st_sel=2: pcm_miss_cycles[15:8].
  - st_sel=3: pcm_miss_cycles[7:0].
- When not defined: no extra ports and no counters. Core behaviour is identical in both cases.

Decomposition:
- Shared package jtpang_romarb_pkg:
  - State enum IDLE/WAIT_ACK/WAIT_RDY.
  - Grant encoding GNT_CPU=0, GNT_PCM=1.
  - Default PCM_OFFSET constant.
- One natural sub-module, jtpang_romarb_cache: valid/tag/word storage, hit compare, byte select. Parameterised by AW and instantiated twice.

Test Plan:
- Reset, then cpu_cs=1, cpu_addr=0x00010, data_read=0xBEEF:
  - sdram_rd=1 with sdram_addr=0x000008.
  - After ack+rdy, cpu_ok=1 and cpu_data=0xEF.
  - cpu_addr=0x00011 then gives cpu_data=0xBE with no new sdram_rd.
- pcm_cs=1, pcm_addr=0x00004:
  - sdram_addr=0x100002.
  - After rdy=0x1234, pcm_data=0x34 with pcm_ok=1.
- Both miss in the same cycle after reset:
  - CPU is granted first, then PCM.
  - Repeat with fresh misses: PCM first, then CPU.
- cpu_addr changed from 0x20 to 0x40 during WAIT_RDY:
  - Cache is filled for tag 0x10 and cpu_ok stays 0.
  - A second request follows with sdram_addr=0x000020.
- sdram_ack and sdram_rdy asserted in the same cycle: one fill, state returns to IDLE, no second sdram_rd.
- rst asserted during WAIT_RDY, then a late sdram_rdy:
  - sdram_rd=0 and both ok=0.
  - Valid bits remain 0 and the cache is not written.
